// File: rtl/riscv_pkg.sv
// Shared core definitions used by the fetch stage.
// Holds architectural widths, reset vector and the fetch FSM state type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = '0;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH,
    STALL,
    HALT
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Handshake bundles of the fetch stage.
// ifu_imem_if: memory request/response; ifu_dec_if: decode hand-off.
interface ifu_imem_if
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_addr;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

interface ifu_dec_if
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] pc;

  modport master (
    output valid, instr, pc,
    input  ready
  );
  modport slave (
    input  valid, instr, pc,
    output ready
  );
endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with clear; push while full is accepted when a pop
// frees the head slot in the same cycle.
module ifu_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign count   = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order buffer to decode.
// Optional IFU_MISALIGN_FAULT_EN: misaligned redirect raises fetch_fault and halts.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH      = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VECTOR),
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  ifu_imem_if.master       imem,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  ifu_dec_if.master        dec,
  output logic             fetch_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e       state, state_n;
  logic [WIDTH-1:0]   pc, tgt, tag_pc;
  logic [2*WIDTH-1:0] ib_out;
  logic [CW-1:0]      drop_cnt, ib_count, tag_count;
  logic [CW:0]        used;
  logic               run, bad, credit, req_valid, accept;
  logic               rsp, keep, pop, dec_valid;
  logic               ib_empty, ib_full, tag_empty, tag_full;
  logic               unused_flags;

  assign unused_flags = ^{ib_full, tag_full};

`ifdef IFU_MISALIGN_FAULT_EN
  logic fault;
  assign bad = |redirect_pc[1:0];
  assign tgt = redirect_pc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault <= 1'b0;
    else if (redirect_valid && bad) fault <= 1'b1;
  end
  assign fetch_fault = fault;
`else
  assign bad = 1'b0;
  assign tgt = redirect_pc & ~WIDTH'(3);
  assign fetch_fault = 1'b0;
`endif

  // Outstanding requests plus buffered words never exceed the buffer size
  assign used   = {1'b0, tag_count} + {1'b0, ib_count};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign accept = req_valid & imem.req_ready;
  assign rsp    = imem.rsp_valid;
  assign keep   = rsp & (drop_cnt == '0) & ~redirect_valid;
  assign dec_valid = ~ib_empty;
  assign pop    = dec_valid & dec.ready & ~redirect_valid;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc;
  assign dec.valid = dec_valid;
  assign dec.pc    = ib_empty ? '0 : ib_out[2*WIDTH-1:WIDTH];
  assign dec.instr = ib_empty ? '0 : ib_out[WIDTH-1:0];

  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    unique case (state)
      FETCH: begin
        req_valid = run & credit;
        if (!credit) state_n = STALL;
      end
      STALL:   if (credit) state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
    if (redirect_valid && state != HALT)
      state_n = bad ? HALT : FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      run      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
      if (redirect_valid) begin
        pc       <= tgt;
        // Every response still due after this edge belongs to the old path
        drop_cnt <= tag_count + CW'(accept) - CW'(rsp);
      end else begin
        if (accept) pc <= pc + WIDTH'(INSTR_BYTES);
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  ifu_sync_fifo #(
    .W     (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tag (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp & ~tag_empty),
    .clear (1'b0),
    .din   (pc),
    .dout  (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  ifu_sync_fifo #(
    .W     (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (pop),
    .clear (redirect_valid),
    .din   ({tag_pc, imem.rsp_data}),
    .dout  (ib_out),
    .count (ib_count),
    .full  (ib_full),
    .empty (ib_empty)
  );
endmodule
